// File: rtl/ib_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ib_pkg
// Purpose  : Packet field layout and lane-counting helpers for the instruction buffer.
// Revision : 1.0
// ---------------------------------------------------------------------------
package ib_pkg;

  localparam int c_MAX_LANES   = 64;

  // Decoded packet layout, LSB first: pc, opcode, dest, src, flags.
  localparam int c_PC_W        = 32;
  localparam int c_OPC_W       = 8;
  localparam int c_DEST_W      = 8;
  localparam int c_SRC_W       = 8;
  localparam int c_FLAGS_LSB   = c_PC_W + c_OPC_W + c_DEST_W + c_SRC_W;
  localparam int c_FLAG_BR_OFF = 4;
  localparam int c_BR_BIT      = c_FLAGS_LSB + c_FLAG_BR_OFF;

  function automatic int unsigned popCount(input logic [c_MAX_LANES-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < c_MAX_LANES; i++) begin
      if (vec[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // Number of set bits strictly below 'lane': the compacted slot of that lane.
  function automatic int unsigned prefixCount(input logic [c_MAX_LANES-1:0] vec,
                                              input int unsigned lane);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < c_MAX_LANES; i++) begin
      if ((i < lane) && vec[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ib_storage_nr_mw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ib_storage_nr_mw
// Purpose  : DEPTH x PKT_W flop array, NUM_WR sync write ports, NUM_RD async read ports.
// Revision : 1.0
// ---------------------------------------------------------------------------
module ib_storage_nr_mw
  import ib_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int PKT_W  = 96,
  parameter int NUM_WR = 8,
  parameter int NUM_RD = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        i_wrEn,
  input  logic [NUM_WR*ADDR_W-1:0] i_wrAddr,
  input  logic [NUM_WR*PKT_W-1:0]  i_wrData,
  input  logic [NUM_RD*ADDR_W-1:0] i_rdAddr,
  output logic [NUM_RD*PKT_W-1:0]  o_rdData
);

  logic [PKT_W-1:0] r_mem [DEPTH];

  // Write addresses are distinct within a cycle, so port order is irrelevant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_wrEn[k]) r_mem[i_wrAddr[k*ADDR_W +: ADDR_W]] <= i_wrData[k*PKT_W +: PKT_W];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rdPort
    assign o_rdData[j*PKT_W +: PKT_W] = r_mem[i_rdAddr[j*ADDR_W +: ADDR_W]];
  end

endmodule
`default_nettype wire

// File: rtl/inst_buffer_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : inst_buffer_gen
// Purpose  : Circular decoded-instruction buffer; compacting multi-lane write,
//            in-order multi-slot dispatch with branch count and occupancy.
// Revision : 1.0
// ---------------------------------------------------------------------------
module inst_buffer_gen
  import ib_pkg::*;
#(
  parameter int FETCH_WIDTH      = 8,
  parameter int DISPATCH_WIDTH   = 4,
  parameter int DEPTH            = 32,
  parameter int PKT_W            = 96,
  parameter int BR_BIT           = c_BR_BIT,
  parameter int PARTIAL_DISPATCH = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]              decodedVector_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]        decodedPackets_i,
  output logic                                stallFetch_o,
  output logic                                instBufferReady_o,
  output logic [DISPATCH_WIDTH-1:0]           dispatchVector_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0]     decodedPackets_o,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0] branchCount_o,
  output logic [$clog2(DEPTH):0]              instCount_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_NIN_W = $clog2(FETCH_WIDTH + 1);
  localparam int c_AV_W  = $clog2(DISPATCH_WIDTH + 1);

  logic [c_PTR_W-1:0]                r_head;
  logic [c_PTR_W-1:0]                r_tail;
  logic [c_CNT_W-1:0]                r_count;

  logic [c_MAX_LANES-1:0]            w_vecExt;
  logic                              w_acc;
  logic [c_NIN_W-1:0]                w_nIn;
  logic [c_AV_W-1:0]                 w_avail;
  logic [c_AV_W-1:0]                 w_nOut;
  logic [c_AV_W-1:0]                 w_brCount;
  logic [FETCH_WIDTH-1:0]            w_wrEn;
  logic [FETCH_WIDTH*c_PTR_W-1:0]    w_wrAddr;
  logic [DISPATCH_WIDTH*c_PTR_W-1:0] w_rdAddr;
  logic [DISPATCH_WIDTH*PKT_W-1:0]   w_rdData;
  logic [DISPATCH_WIDTH-1:0]         w_dispVec;

  assign w_vecExt     = c_MAX_LANES'(decodedVector_i);
  assign stallFetch_o = (c_CNT_W'(DEPTH) - r_count) < c_CNT_W'(FETCH_WIDTH);
  assign w_acc        = decodeReady_i & ~stallFetch_o;
  assign w_nIn        = w_acc ? c_NIN_W'(popCount(w_vecExt)) : '0;

  // Sparse lanes land in contiguous entries: lane k goes to tail + (set lanes below k).
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_wrLane
    assign w_wrEn[k] = w_acc & decodedVector_i[k] & ~flush_i;
    assign w_wrAddr[k*c_PTR_W +: c_PTR_W] = r_tail + c_PTR_W'(prefixCount(w_vecExt, k));
  end

  always_comb begin
    w_avail = '0;
    if (r_count >= c_CNT_W'(DISPATCH_WIDTH)) begin
      w_avail = c_AV_W'(DISPATCH_WIDTH);
    end else if (PARTIAL_DISPATCH != 0) begin
      w_avail = c_AV_W'(r_count);
    end
  end

  for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_rdSlot
    assign w_rdAddr[j*c_PTR_W +: c_PTR_W] = r_head + c_PTR_W'(j);
    assign w_dispVec[j] = (c_AV_W'(j) < w_avail);
  end

  always_comb begin
    w_brCount = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (w_dispVec[j] && w_rdData[j*PKT_W + BR_BIT]) w_brCount = w_brCount + c_AV_W'(1);
    end
  end

  assign w_nOut = stall_i ? '0 : w_avail;

  ib_storage_nr_mw #(
    .DEPTH  (DEPTH),
    .PKT_W  (PKT_W),
    .NUM_WR (FETCH_WIDTH),
    .NUM_RD (DISPATCH_WIDTH),
    .ADDR_W (c_PTR_W)
  ) u_storage (
    .clk      (clk),
    .reset    (reset),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_wrAddr),
    .i_wrData (decodedPackets_i),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  // Count stays within 0..DEPTH, so modular arithmetic at count width is exact.
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PTR_W'(w_nOut);
      r_tail  <= r_tail + c_PTR_W'(w_nIn);
      r_count <= r_count + c_CNT_W'(w_nIn) - c_CNT_W'(w_nOut);
    end
  end

  a_countBound: assert property (@(posedge clk) disable iff (!reset)
    r_count <= c_CNT_W'(DEPTH));
  a_ptrCoherent: assert property (@(posedge clk) disable iff (!reset)
    (r_tail - r_head) == r_count[c_PTR_W-1:0]);

  assign instBufferReady_o = (w_avail != '0);
  assign dispatchVector_o  = w_dispVec;
  assign decodedPackets_o  = w_rdData;
  assign branchCount_o     = w_brCount;
  assign instCount_o       = r_count;

endmodule
`default_nettype wire
